// File: rtl/shader_issue_sequencer.sv
// Round-robin issue sequencer sharing one shader_core between NUM_REQ thread contexts.
// Holds fields through the core's delayed writeback and runs load/store through a mem handshake.
module shader_issue_sequencer #(
  parameter int unsigned     NUM_REQ  = 4,
  parameter int unsigned     OP_W     = 5,
  parameter int unsigned     REG_AW   = 4,
  parameter logic [OP_W-1:0] OP_LOAD  = 5'h10,
  parameter logic [OP_W-1:0] OP_STORE = 5'h11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*OP_W-1:0]    i_req_opcode,
  input  logic [NUM_REQ*REG_AW-1:0]  i_req_rd,
  input  logic [NUM_REQ*REG_AW-1:0]  i_req_rs1,
  input  logic [NUM_REQ*REG_AW-1:0]  i_req_rs2,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_exec_en,
  output logic [OP_W-1:0]            o_opcode,
  output logic [REG_AW-1:0]          o_rd_addr,
  output logic [REG_AW-1:0]          o_rs1_addr,
  output logic [REG_AW-1:0]          o_rs2_addr,
  output logic                       o_mem_req,
  input  logic                       i_mem_ready,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StExec, StWb, StMem} state_e;

  state_e            state_q;
  logic [IDW-1:0]    ptr_q;
  logic              accept_slot;
  logic              grant_valid;
  logic [IDW-1:0]    grant_idx;
  logic [31:0]       scan_sum;
  logic [OP_W-1:0]   gnt_opcode;
  logic [REG_AW-1:0] gnt_rd;
  logic [REG_AW-1:0] gnt_rs1;
  logic [REG_AW-1:0] gnt_rs2;
  logic              gnt_is_mem;

  assign accept_slot = (state_q == StIdle) || (state_q == StWb) ||
                       ((state_q == StMem) && i_mem_ready);

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_sum = 32'(ptr_q) + i;
      if (scan_sum >= NUM_REQ) begin
        scan_sum = scan_sum - NUM_REQ;
      end
      if (!grant_valid && i_req_valid[scan_sum[IDW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt_opcode = '0;
    gnt_rd     = '0;
    gnt_rs1    = '0;
    gnt_rs2    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        gnt_opcode = i_req_opcode[k*OP_W +: OP_W];
        gnt_rd     = i_req_rd[k*REG_AW +: REG_AW];
        gnt_rs1    = i_req_rs1[k*REG_AW +: REG_AW];
        gnt_rs2    = i_req_rs2[k*REG_AW +: REG_AW];
      end
    end
  end

  assign gnt_is_mem = (gnt_opcode == OP_LOAD) || (gnt_opcode == OP_STORE);

  // Ready is suppressed during reset so nothing is handed over that the reset would drop.
  always_comb begin
    o_req_ready = '0;
    if (!rst && accept_slot && grant_valid) begin
      o_req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      o_exec_en  <= 1'b0;
      o_mem_req  <= 1'b0;
      o_opcode   <= '0;
      o_rd_addr  <= '0;
      o_rs1_addr <= '0;
      o_rs2_addr <= '0;
      o_grant_id <= '0;
    end else if (accept_slot) begin
      if (grant_valid) begin
        ptr_q      <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        o_opcode   <= gnt_opcode;
        o_rd_addr  <= gnt_rd;
        o_rs1_addr <= gnt_rs1;
        o_rs2_addr <= gnt_rs2;
        o_grant_id <= grant_idx;
        if (gnt_is_mem) begin
          state_q   <= StMem;
          o_exec_en <= 1'b0;
          o_mem_req <= 1'b1;
        end else begin
          state_q   <= StExec;
          o_exec_en <= 1'b1;
          o_mem_req <= 1'b0;
        end
      end else begin
        state_q   <= StIdle;
        o_exec_en <= 1'b0;
        o_mem_req <= 1'b0;
      end
    end else if (state_q == StExec) begin
      // Fields stay put through WB: the core writes back using the current rd.
      state_q   <= StWb;
      o_exec_en <= 1'b0;
    end
  end

  assign o_busy = (state_q != StIdle);

endmodule

// File: tb/tb_shader_issue_sequencer.sv
// Directed-vector bench for shader_issue_sequencer with hand-computed expectations.
module tb_shader_issue_sequencer;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_AW  = 4;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*OP_W-1:0]   req_opcode;
  logic [NUM_REQ*REG_AW-1:0] req_rd;
  logic [NUM_REQ*REG_AW-1:0] req_rs1;
  logic [NUM_REQ*REG_AW-1:0] req_rs2;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      exec_en;
  logic [OP_W-1:0]           opcode;
  logic [REG_AW-1:0]         rd_addr;
  logic [REG_AW-1:0]         rs1_addr;
  logic [REG_AW-1:0]         rs2_addr;
  logic                      mem_req;
  logic                      mem_ready;
  logic [1:0]                grant_id;
  logic                      busy;

  int unsigned n_tests;
  int unsigned n_fail;

  shader_issue_sequencer #(
    .NUM_REQ (NUM_REQ),
    .OP_W    (OP_W),
    .REG_AW  (REG_AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (req_valid),
    .i_req_opcode (req_opcode),
    .i_req_rd     (req_rd),
    .i_req_rs1    (req_rs1),
    .i_req_rs2    (req_rs2),
    .o_req_ready  (req_ready),
    .o_exec_en    (exec_en),
    .o_opcode     (opcode),
    .o_rd_addr    (rd_addr),
    .o_rs1_addr   (rs1_addr),
    .o_rs2_addr   (rs2_addr),
    .o_mem_req    (mem_req),
    .i_mem_ready  (mem_ready),
    .o_grant_id   (grant_id),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [4:0] op, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2);
    req_opcode[k*OP_W +: OP_W]   = op;
    req_rd[k*REG_AW +: REG_AW]   = rd;
    req_rs1[k*REG_AW +: REG_AW]  = rs1;
    req_rs2[k*REG_AW +: REG_AW]  = rs2;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req_valid  = '0;
    req_opcode = '0;
    req_rd     = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    mem_ready  = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_exec_en", exec_en, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_opcode", opcode, 0);
    check_eq("rst_rd", rd_addr, 0);
    check_eq("rst_grant_id", grant_id, 0);

    // 1: single op from IDLE
    rst = 1'b0;
    set_req(0, 5'h01, 4'd3, 4'd1, 4'd2);
    req_valid = 4'b0001;
    #1;
    check_eq("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check_eq("t1_exec_c1", exec_en, 1);
    check_eq("t1_rd_c1", rd_addr, 3);
    check_eq("t1_rs1_c1", rs1_addr, 1);
    check_eq("t1_rs2_c1", rs2_addr, 2);
    check_eq("t1_op_c1", opcode, 5'h01);
    check_eq("t1_busy_c1", busy, 1);
    tick();
    check_eq("t1_exec_c2", exec_en, 0);
    check_eq("t1_rd_c2", rd_addr, 3);
    tick();
    check_eq("t1_idle_c3", busy, 0);

    // 2: all requesters valid -> 0,1,2,3,0 every second cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) set_req(k, 5'(k + 1), 4'(k + 4), 4'(k), 4'(k + 8));
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      check_eq("t2_ready", req_ready, 4'b0001 << (g % 4));
      tick();
      check_eq("t2_exec_hi", exec_en, 1);
      check_eq("t2_gid", grant_id, g % 4);
      check_eq("t2_rd", rd_addr, (g % 4) + 4);
      tick();
      check_eq("t2_exec_lo", exec_en, 0);
      check_eq("t2_rd_held", rd_addr, (g % 4) + 4);
    end
    req_valid = '0;
    tick();
    check_eq("t2_idle", busy, 0);

    // 3: load on req2 with 5 stalled cycles; req1 waits for the mem_ready cycle
    set_req(2, 5'h10, 4'd7, 4'd5, 4'd6);
    set_req(1, 5'h02, 4'd9, 4'd1, 4'd1);
    req_valid = 4'b0100;
    #1;
    check_eq("t3_ready_load", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0010;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_mem_req", mem_req, 1);
      check_eq("t3_exec_lo", exec_en, 0);
      check_eq("t3_rd_held", rd_addr, 7);
      check_eq("t3_gid", grant_id, 2);
      check_eq("t3_no_ready", req_ready, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_eq("t3_mem_req_c6", mem_req, 1);
    check_eq("t3_ready_req1", req_ready, 4'b0010);
    tick();
    mem_ready = 1'b0;
    req_valid = '0;
    check_eq("t3_mem_req_drop", mem_req, 0);
    check_eq("t3_exec_req1", exec_en, 1);
    check_eq("t3_rd_req1", rd_addr, 9);
    check_eq("t3_gid_req1", grant_id, 1);
    tick();
    tick();

    // 4: ptr=3, only req1 valid -> wrap to 1, ptr becomes 2
    for (int k = 0; k < 4; k++) set_req(k, 5'(k + 3), 4'(k), 4'(k), 4'(k));
    req_valid = 4'b0100;
    #1;
    check_eq("t4_ready_req2", req_ready, 4'b0100);
    tick();
    req_valid = 4'b0010;
    #1;
    check_eq("t4_exec_no_ready", req_ready, 0);
    tick();
    check_eq("t4_wrap_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1111;
    check_eq("t4_gid_wrap", grant_id, 1);
    tick();
    check_eq("t4_ptr_after", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check_eq("t4_gid2", grant_id, 2);
    tick();
    tick();

    // 5: reset while in MEM
    set_req(0, 5'h10, 4'd2, 4'd2, 4'd2);
    req_valid = 4'b0001;
    tick();
    check_eq("t5_in_mem", mem_req, 1);
    req_valid = 4'b1000;
    rst = 1'b1;
    tick();
    check_eq("t5_mem_req", mem_req, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_no_ready_a", req_ready, 0);
    tick();
    check_eq("t5_no_ready_b", req_ready, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) set_req(k, 5'h05, 4'd1, 4'd1, 4'd1);
    req_valid = 4'b1111;
    #1;
    check_eq("t5_ptr_zero", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();

    // 6: back-to-back stores with mem_ready held high
    set_req(1, 5'h11, 4'd11, 4'd0, 4'd0);
    set_req(2, 5'h11, 4'd12, 4'd0, 4'd0);
    req_valid = 4'b0110;
    mem_ready = 1'b1;
    #1;
    check_eq("t6_ready1", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0100;
    #1;
    check_eq("t6_mem_req_a", mem_req, 1);
    check_eq("t6_rd_a", rd_addr, 11);
    check_eq("t6_ready2", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check_eq("t6_mem_req_b", mem_req, 1);
    check_eq("t6_rd_b", rd_addr, 12);
    check_eq("t6_gid_b", grant_id, 2);
    check_eq("t6_exec_lo", exec_en, 0);
    tick();
    mem_ready = 1'b0;
    check_eq("t6_mem_req_end", mem_req, 0);
    check_eq("t6_busy_end", busy, 0);
    check_eq("t6_rd_kept", rd_addr, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
